// File: rtl/spi_shifter_if.sv
// Bus between the SPI host control logic / clock generator and the serial shift engine.
// Handshake: go is a one-cycle request taken only while tip=0; tip stays high for the
// whole character, and done pulses for exactly one cycle in the cycle tip falls.
interface spi_shifter_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
);
  logic              go;
  logic [LEN_W-1:0]  len;
  logic              lsb;
  logic              tx_negedge;
  logic              rx_negedge;
  logic [DATA_W-1:0] tx_data;
  logic              pos_edge;
  logic              neg_edge;
  logic              s_in;
  logic              tip;
  logic              last;
  logic              done;
  logic              s_out;
  logic [DATA_W-1:0] rx_data;
  logic              dbg_state;

  modport slave (
    input  go, len, lsb, tx_negedge, rx_negedge, tx_data, pos_edge, neg_edge, s_in,
    output tip, last, done, s_out, rx_data, dbg_state
  );

  modport master (
    output go, len, lsb, tx_negedge, rx_negedge, tx_data, pos_edge, neg_edge, s_in,
    input  tip, last, done, s_out, rx_data, dbg_state
  );
endinterface

// File: rtl/spi_shifter.sv
// SPI serial data engine: shifts a 1..DATA_W bit character out on MOSI, samples MISO,
// and steers the SCLK generator's enable/last_clk so exactly len pulses are produced.
module spi_shifter #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
) (
  input logic         clk_in,
  input logic         rst,
  spi_shifter_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  localparam logic [LEN_W:0] FULL_LEN = (LEN_W + 1)'(DATA_W);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              lsb_q, lsb_d;
  logic [LEN_W:0]    len_q, len_d;
  logic [LEN_W:0]    rx_cnt_q, rx_cnt_d;
  logic [LEN_W:0]    pos_cnt_q, pos_cnt_d;
  logic              s_out_q, s_out_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              done_q, done_d;

  logic [LEN_W:0]    eff_len;
  logic [LEN_W-1:0]  first_idx;
  logic [LEN_W-1:0]  bit_idx;
  logic              tx_clk;
  logic              rx_clk;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_buf_q  <= '0;
      lsb_q     <= 1'b0;
      len_q     <= '0;
      rx_cnt_q  <= '0;
      pos_cnt_q <= '0;
      s_out_q   <= 1'b0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_buf_q  <= tx_buf_d;
      lsb_q     <= lsb_d;
      len_q     <= len_d;
      rx_cnt_q  <= rx_cnt_d;
      pos_cnt_q <= pos_cnt_d;
      s_out_q   <= s_out_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    eff_len   = (bus.len == '0) ? FULL_LEN : {1'b0, bus.len};
    first_idx = bus.lsb ? '0 : LEN_W'(eff_len - 1'b1);
    // Same index serves tx and rx; it walks with the pre-decrement rx_cnt.
    bit_idx   = lsb_q ? LEN_W'(len_q - rx_cnt_q) : LEN_W'(rx_cnt_q - 1'b1);
    tx_clk    = bus.tx_negedge ? bus.neg_edge : bus.pos_edge;
    rx_clk    = bus.rx_negedge ? bus.neg_edge : bus.pos_edge;

    state_d   = state_q;
    tx_buf_d  = tx_buf_q;
    lsb_d     = lsb_q;
    len_d     = len_q;
    rx_cnt_d  = rx_cnt_q;
    pos_cnt_d = pos_cnt_q;
    s_out_d   = s_out_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.go) begin
          tx_buf_d  = bus.tx_data;
          lsb_d     = bus.lsb;
          len_d     = eff_len;
          rx_data_d = '0;
          rx_cnt_d  = eff_len;
          pos_cnt_d = '0;
          s_out_d   = bus.tx_data[first_idx];
          state_d   = XFER;
        end
      end
      XFER: begin
        if (tx_clk && rx_cnt_q != '0) s_out_d = tx_buf_q[bit_idx];
        if (rx_clk && rx_cnt_q != '0) begin
          rx_data_d[bit_idx] = bus.s_in;
          rx_cnt_d           = rx_cnt_q - 1'b1;
        end
        if (bus.pos_edge && pos_cnt_q != len_q) pos_cnt_d = pos_cnt_q + 1'b1;
        // Ending only on a falling strobe guarantees SCLK is parked low.
        if (bus.neg_edge && pos_cnt_q == len_q && rx_cnt_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.tip       = (state_q == XFER);
    bus.last      = (state_q == XFER) && (pos_cnt_q == len_q);
    bus.done      = done_q;
    bus.s_out     = s_out_q;
    bus.rx_data   = rx_data_q;
    bus.dbg_state = state_q;
  end
endmodule

// File: tb/tb_spi_shifter.sv
// Bench for spi_shifter: behavioural SCLK generator, directed scenarios and random transfers
// checked against a bit-order reference model.
module tb_spi_shifter;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 5;
  localparam int M_RAND = 0, M_LOOP = 1, M_ONE = 2, M_ZERO = 3;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  spi_shifter_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  spi_shifter #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  // behavioural SCLK generator: half-period of div+1 cycles, no rise once last is high
  int   div = 0;
  int   gcnt;
  logic sclk, pos_s, neg_s;
  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sclk <= 1'b0; pos_s <= 1'b0; neg_s <= 1'b0; gcnt <= 0;
    end else if (!bus.tip) begin
      sclk <= 1'b0; pos_s <= 1'b0; neg_s <= 1'b0; gcnt <= div;
    end else if (gcnt == 0) begin
      gcnt <= div;
      if (sclk) begin
        sclk <= 1'b0; neg_s <= 1'b1; pos_s <= 1'b0;
      end else if (!bus.last) begin
        sclk <= 1'b1; pos_s <= 1'b1; neg_s <= 1'b0;
      end else begin
        pos_s <= 1'b0; neg_s <= 1'b0;
      end
    end else begin
      gcnt <= gcnt - 1; pos_s <= 1'b0; neg_s <= 1'b0;
    end
  end

  int   miso_mode = M_RAND;
  logic miso_rand = 1'b0;
  always @(posedge clk_in) begin
    #2 miso_rand = 1'($urandom_range(0, 1));
  end

  assign bus.pos_edge = pos_s;
  assign bus.neg_edge = neg_s;
  assign bus.s_in = (miso_mode == M_LOOP) ? bus.s_out :
                    (miso_mode == M_ONE)  ? 1'b1 :
                    (miso_mode == M_ZERO) ? 1'b0 : miso_rand;

  // scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver + monitor for one character
  task automatic run_xfer(input logic [DATA_W-1:0] tx, input logic [LEN_W-1:0] ln,
                          input logic lsb_i, input logic txn, input logic rxn,
                          input int mode, input int dv, input int mid_go,
                          input int abort_at, input bit chk_lat);
    int n, samples, rises, dones, lasts, lat, pos;
    bit finished;
    logic [DATA_W-1:0] rxv, mask;
    div = dv;
    miso_mode = mode;
    n = (ln == '0) ? DATA_W : int'(ln);
    mask = (n == DATA_W) ? '1 : ((DATA_W'(1) << n) - 1);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(DATA_W'(lsb_i ? tx[k] : tx[n-1-k]));

    @(negedge clk_in);
    bus.tx_data = tx; bus.len = ln; bus.lsb = lsb_i;
    bus.tx_negedge = txn; bus.rx_negedge = rxn; bus.go = 1'b1;
    @(negedge clk_in);
    bus.go = 1'b0;
    check("tip_after_go", DATA_W'(bus.tip), 1);

    samples = 0; rises = 0; dones = 0; lasts = 0; lat = 0; rxv = '0; finished = 0;
    for (int i = 1; i <= 4000 && !finished; i++) begin
      bus.go = (mid_go != 0 && i == mid_go);
      if (bus.go) bus.tx_data = 'hFF;
      if (bus.done) begin
        dones++; lat = i - 1; finished = 1;
      end else begin
        if (bus.last) lasts++;
        if (pos_s) rises++;
        if (rxn ? neg_s : pos_s) begin
          if (samples < n) begin
            pos = lsb_i ? samples : n - 1 - samples;
            rxv[pos] = bus.s_in;
            if (txn != rxn) check("mosi_bit", DATA_W'(bus.s_out), exp_q.pop_front());
          end
          samples++;
        end
        if (abort_at > 0 && samples == abort_at) begin
          rst = 1'b1;
          #1;
          check("abort_tip", DATA_W'(bus.tip), 0);
          check("abort_last", DATA_W'(bus.last), 0);
          check("abort_done", DATA_W'(bus.done), 0);
          check("abort_s_out", DATA_W'(bus.s_out), 0);
          check("abort_rx_data", bus.rx_data, 0);
          return;
        end
        @(negedge clk_in);
      end
    end
    bus.go = 1'b0;
    check("done_seen", DATA_W'(finished), 1);
    check("rx_samples", DATA_W'(samples), DATA_W'(n));
    check("sclk_rises", DATA_W'(rises), DATA_W'(n));
    check("rx_data", bus.rx_data, rxv);
    if (mode == M_LOOP) check("rx_loopback", bus.rx_data, tx & mask);
    if (txn != rxn) check("mosi_all_used", DATA_W'(exp_q.size()), 0);
    check("tip_at_done", DATA_W'(bus.tip), 0);
    if (chk_lat) begin
      check("done_latency", DATA_W'(lat), 3);
      check("last_cycles", DATA_W'(lasts), 1);
    end
    @(negedge clk_in);
    check("done_single", DATA_W'(dones + int'(bus.done)), 1);
    check("sclk_low", DATA_W'(sclk), 0);
    check("rx_hold", bus.rx_data, rxv);
  endtask

  initial begin
    logic [LEN_W-1:0] r_len;
    logic r_txn, r_rxn;
    int r_mode;
    bus.go = 1'b0; bus.len = '0; bus.lsb = 1'b0; bus.tx_negedge = 1'b1;
    bus.rx_negedge = 1'b0; bus.tx_data = '0;
    repeat (3) @(negedge clk_in);
    check("rst_tip", DATA_W'(bus.tip), 0);
    check("rst_last", DATA_W'(bus.last), 0);
    check("rst_done", DATA_W'(bus.done), 0);
    check("rst_s_out", DATA_W'(bus.s_out), 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_state", DATA_W'(bus.dbg_state), 0);
    rst = 1'b0;

    run_xfer(32'hA5, 5'd8, 1'b0, 1'b1, 1'b0, M_LOOP, 2, 0, 0, 0);
    check("mode0_a5", bus.rx_data, 32'h0000_00A5);

    run_xfer(32'h8000_0001, 5'd0, 1'b1, 1'b1, 1'b0, M_LOOP, 1, 0, 0, 0);
    check("len0_lsb", bus.rx_data, 32'h8000_0001);

    run_xfer($urandom, 5'd5, 1'b0, 1'b0, 1'b1, M_ONE, 1, 0, 0, 0);
    check("miso_ones", bus.rx_data, 32'h0000_001F);
    run_xfer($urandom, 5'd5, 1'b0, 1'b0, 1'b1, M_ZERO, 1, 0, 0, 0);
    check("miso_zeros", bus.rx_data, 32'h0);

    run_xfer(32'h3C, 5'd8, 1'b0, 1'b1, 1'b0, M_LOOP, 2, 6, 0, 0);
    check("mid_go_ignored", bus.rx_data, 32'h3C);

    run_xfer(32'hC3, 5'd8, 1'b0, 1'b1, 1'b0, M_LOOP, 2, 0, 3, 0);
    @(negedge clk_in);
    rst = 1'b0;
    run_xfer(32'h9, 5'd4, 1'b0, 1'b1, 1'b0, M_LOOP, 1, 0, 0, 0);
    check("after_abort", bus.rx_data, 32'h9);

    run_xfer(32'h1, 5'd1, 1'b0, 1'b1, 1'b0, M_LOOP, 0, 0, 0, 1);
    check("div0_len1", bus.rx_data, 32'h1);

    for (int t = 0; t < 24; t++) begin
      r_len  = LEN_W'($urandom_range(0, 31));
      r_txn  = 1'($urandom_range(0, 1));
      r_rxn  = 1'($urandom_range(0, 1));
      r_mode = (r_txn != r_rxn && $urandom_range(0, 1) == 1) ? M_LOOP : M_RAND;
      run_xfer($urandom, r_len, 1'($urandom_range(0, 1)), r_txn, r_rxn, r_mode,
               $urandom_range(0, 3), 0, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
